ram_mport_arb: RTL and testbench

//  - Parametrised multi-port front end for one single-port synchronous SRAM macro.
//  - NUM_PORTS masters issue valid/ready requests; a round-robin arbiter grants one per cycle.
//  - Tracks the granted port through the SRAM read pipeline and returns a per-port response pulse.
//  - Sits between CPU/DMA masters and an on-chip SRAM bank; generalises the fixed 15b/32b RAM port.

---
 rtl/ram_mport_arb.sv | 136 +++++++++++++
 tb/tb_ram_mport_arb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_mport_arb.sv
`default_nettype none
// ============================================================================
// ram_mport_arb : round-robin multi-master front end for one single-port SRAM
// Optional RAM_MPORT_OUTREG_EN adds a registered response stage (latency 2).
// Revision 1.0
// ============================================================================
module ram_mport_arb #(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_WIDTH  = 15,
  parameter int DATA_WIDTH  = 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic [NUM_PORTS-1:0]             req_valid_i,
  output logic [NUM_PORTS-1:0]             req_ready_o,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata_i,
  input  logic [NUM_PORTS*STRB_WIDTH-1:0]  req_wstrb_i,
  output logic [NUM_PORTS-1:0]             rsp_valid_o,
  output logic [DATA_WIDTH-1:0]            rsp_rdata_o,
  output logic                             ram_en_o,
  output logic [ADDR_WIDTH-1:0]            ram_addr_o,
  output logic [DATA_WIDTH-1:0]            ram_wdata_o,
  output logic [STRB_WIDTH-1:0]            ram_wstrb_o,
  input  logic [DATA_WIDTH-1:0]            ram_rdata_i
);

  localparam int PTR_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // Port index arithmetic that wraps at NUM_PORTS (not necessarily a power of two).
  function automatic logic [PTR_WIDTH-1:0] wrap_inc(input logic [PTR_WIDTH-1:0] base,
                                                    input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
    return PTR_WIDTH'(sum);
  endfunction

  logic [PTR_WIDTH-1:0] rr_q;
  logic [PTR_WIDTH-1:0] grant_id;
  logic [NUM_PORTS-1:0] grant;
  logic                 grant_found;
  logic                 any_valid;
  logic                 is_read;

  logic                 s1_valid;
  logic [PTR_WIDTH-1:0] s1_id;
  logic                 s1_read;
  logic [NUM_PORTS-1:0] s1_onehot;
  logic [DATA_WIDTH-1:0] s1_rdata;

  assign any_valid = |req_valid_i;

  always_comb begin
    grant       = '0;
    grant_id    = rr_q;
    grant_found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!grant_found && req_valid_i[wrap_inc(rr_q, i)]) begin
        grant_found = 1'b1;
        grant_id    = wrap_inc(rr_q, i);
      end
    end
    if (grant_found) grant[grant_id] = 1'b1;
  end

  assign req_ready_o = grant;
  assign ram_en_o    = any_valid;

  always_comb begin
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_wstrb_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant[p]) begin
        ram_addr_o  = req_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
        ram_wdata_o = req_wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
        ram_wstrb_o = req_wstrb_i[p*STRB_WIDTH +: STRB_WIDTH];
      end
    end
  end

  assign is_read = (ram_wstrb_o == '0);

  // Every cycle with any valid is a handshake, so the pointer moves past the winner.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_q <= '0;
    end else if (any_valid) begin
      rr_q <= wrap_inc(grant_id, 1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_read  <= 1'b0;
    end else begin
      s1_valid <= any_valid;
      s1_id    <= grant_id;
      s1_read  <= is_read;
    end
  end

  always_comb begin
    s1_onehot = '0;
    if (s1_valid) s1_onehot[s1_id] = 1'b1;
  end

  assign s1_rdata = (s1_valid && s1_read) ? ram_rdata_i : '0;

`ifdef RAM_MPORT_OUTREG_EN
  logic [NUM_PORTS-1:0]  s2_valid;
  logic [DATA_WIDTH-1:0] s2_rdata;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s2_valid <= '0;
      s2_rdata <= '0;
    end else begin
      s2_valid <= s1_onehot;
      s2_rdata <= s1_rdata;
    end
  end

  assign rsp_valid_o = s2_valid;
  assign rsp_rdata_o = s2_rdata;
`else
  assign rsp_valid_o = s1_onehot;
  assign rsp_rdata_o = s1_rdata;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_mport_arb.sv
`default_nettype none
// ============================================================================
// tb_ram_mport_arb : 2-port and 4-port instances driven by shared stimulus,
// each checked every cycle against a behavioural arbiter/SRAM model.
// Revision 1.0
// ============================================================================
module tb_ram_mport_arb;

  localparam int AW   = 15;
  localparam int DW   = 32;
  localparam int SW   = 4;
  localparam int MAXP = 4;
`ifdef RAM_MPORT_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [MAXP-1:0]    valid;
  logic [MAXP*AW-1:0] addr;
  logic [MAXP*DW-1:0] wdata;
  logic [MAXP*SW-1:0] wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
  } exp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first valid port at or after the pointer, wrapping at np.
  function automatic int pick(input logic [MAXP-1:0] v, input int np, input int ptr);
    for (int i = 0; i < np; i++) begin
      int j;
      j = (ptr + i) % np;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_env
    localparam int NP = (k == 0) ? 2 : 4;

    logic [NP-1:0] ready, rsp_valid;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata, rsp_rdata;
    logic [SW-1:0] ram_wstrb;

    logic [DW-1:0] sram [int];
    logic [DW-1:0] mdl  [int];
    int            rr  = 0;
    int            cyc = 0;
    exp_t          q[$];

    ram_mport_arb #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .req_valid_i (valid[NP-1:0]),
      .req_ready_o (ready),
      .req_addr_i  (addr[NP*AW-1:0]),
      .req_wdata_i (wdata[NP*DW-1:0]),
      .req_wstrb_i (wstrb[NP*SW-1:0]),
      .rsp_valid_o (rsp_valid),
      .rsp_rdata_o (rsp_rdata),
      .ram_en_o    (ram_en),
      .ram_addr_o  (ram_addr),
      .ram_wdata_o (ram_wdata),
      .ram_wstrb_o (ram_wstrb),
      .ram_rdata_i (ram_rdata)
    );

    // SRAM macro: read data valid one cycle after the enable.
    initial begin
      logic [DW-1:0] cur;
      ram_rdata = '0;
      forever begin
        @(posedge clk);
        if (ram_en) begin
          cur = sram.exists(int'(ram_addr)) ? sram[int'(ram_addr)] : '0;
          if (ram_wstrb == '0) ram_rdata <= cur;
          else sram[int'(ram_addr)] = merge(cur, ram_wdata, ram_wstrb);
        end
      end
    end

    // Reference model: accepted requests become expected responses LAT cycles later.
    initial begin
      int          g;
      logic [AW-1:0] a;
      logic [31:0] d, cur;
      logic [3:0]  s;
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          rr = 0;
          q.delete();
        end else begin
          g = pick(valid, NP, rr);
          if (g >= 0) begin
            a   = addr[g*AW +: AW];
            d   = wdata[g*DW +: DW];
            s   = wstrb[g*SW +: SW];
            cur = mdl.exists(int'(a)) ? mdl[int'(a)] : '0;
            if (s == '0) begin
              q.push_back('{due: cyc + LAT, port: g, data: cur});
            end else begin
              mdl[int'(a)] = merge(cur, d, s);
              q.push_back('{due: cyc + LAT, port: g, data: 32'h0});
            end
            rr = (g + 1) % NP;
          end
        end
        cyc++;
      end
    end

    initial begin
      int            eg;
      logic [NP-1:0] e_ready, e_rv;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata, e_rdata;
      logic [SW-1:0] e_wstrb;
      forever begin
        @(negedge clk);
        eg = pick(valid, NP, rr);
        e_ready = '0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
        if (eg >= 0) begin
          e_ready[eg] = 1'b1;
          e_addr  = addr[eg*AW +: AW];
          e_wdata = wdata[eg*DW +: DW];
          e_wstrb = wstrb[eg*SW +: SW];
        end
        while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
        e_rv = '0; e_rdata = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
          e_rv[q[0].port] = 1'b1;
          e_rdata = q[0].data;
          void'(q.pop_front());
        end
        chk($sformatf("np%0d ready", NP),     64'(ready),     64'(e_ready));
        chk($sformatf("np%0d ram_en", NP),    64'(ram_en),    64'(eg >= 0));
        chk($sformatf("np%0d ram_addr", NP),  64'(ram_addr),  64'(e_addr));
        chk($sformatf("np%0d ram_wdata", NP), 64'(ram_wdata), 64'(e_wdata));
        chk($sformatf("np%0d ram_wstrb", NP), 64'(ram_wstrb), 64'(e_wstrb));
        chk($sformatf("np%0d rsp_valid", NP), 64'(rsp_valid), 64'(e_rv));
        chk($sformatf("np%0d rsp_rdata", NP), 64'(rsp_rdata), 64'(e_rdata));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = '0; addr = '0; wdata = '0; wstrb = '0;
  endtask

  task automatic drive(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s);
    valid[p]          = 1'b1;
    addr[p*AW +: AW]  = a;
    wdata[p*DW +: DW] = d;
    wstrb[p*SW +: SW] = s;
  endtask

  // One request, then wait until its response is visible.
  task automatic req1(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] s);
    idle();
    drive(p, a, d, s);
    tick();
    idle();
    repeat (LAT - 1) tick();
  endtask

  logic [1:0] seq2 [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  int         seq4 [8] = '{0, 1, 2, 3, 0, 1, 3, 0};

  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    chk("reset rsp_valid np2", 64'(g_env[0].rsp_valid), 64'h0);
    chk("reset rsp_rdata np4", 64'(g_env[1].rsp_rdata), 64'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    req1(0, 15'h12, 32'hDEADBEEF, 4'hF);
    chk("write ack valid", 64'(g_env[0].rsp_valid), 64'h1);
    chk("write ack rdata", 64'(g_env[0].rsp_rdata), 64'h0);
    req1(0, 15'h12, 32'h0, 4'h0);
    chk("read valid", 64'(g_env[0].rsp_valid), 64'h1);
    chk("read data", 64'(g_env[0].rsp_rdata), 64'hDEADBEEF);
    chk("read data np4", 64'(g_env[1].rsp_rdata), 64'hDEADBEEF);

    req1(1, 15'h40, 32'h11223344, 4'hF);
    req1(1, 15'h40, 32'h0000AA00, 4'h2);
    req1(1, 15'h40, 32'h0, 4'h0);
    chk("strobe valid", 64'(g_env[0].rsp_valid), 64'h2);
    chk("strobe data", 64'(g_env[0].rsp_rdata), 64'h1122AA44);

    idle(); drive(0, 15'h7FFF, 32'hA5A5A5A5, 4'hF); tick();
    idle(); drive(1, 15'h0000, 32'h5A5A5A5A, 4'hF); tick();
    idle(); drive(1, 15'h0000, 32'h0, 4'h0); tick();
    idle(); drive(0, 15'h7FFF, 32'h0, 4'h0); tick();
    idle();
    repeat (LAT - 1) tick();
    chk("edge addr valid", 64'(g_env[0].rsp_valid), 64'h1);
    chk("edge addr data", 64'(g_env[0].rsp_rdata), 64'hA5A5A5A5);
    tick();

    idle(); drive(0, 15'h12, 32'h0, 4'h0); tick();
    idle();
    rst_n = 1'b0;
    #1;
    chk("midreset rsp_valid", 64'(g_env[0].rsp_valid), 64'h0);
    chk("midreset rsp_rdata", 64'(g_env[0].rsp_rdata), 64'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no stale pulse", 64'(g_env[0].rsp_valid), 64'h0);
    end

    idle();
    drive(0, 15'h12, 32'h0, 4'h0);
    drive(1, 15'h40, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("contention grant", 64'(g_env[0].ready), 64'(seq2[i]));
      if (i >= LAT) chk("contention rsp", 64'(g_env[0].rsp_valid), 64'(seq2[i-LAT]));
      tick();
    end
    idle();
    repeat (LAT + 1) tick();

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int p = 0; p < 4; p++) drive(p, AW'(p * 3 + 1), 32'h0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) valid[2] = 1'b0;
      #1;
      chk("fairness grant", 64'(g_env[1].ready), 64'h1 << seq4[i]);
      tick();
    end
    idle();
    repeat (LAT + 1) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
